// File: rtl/conv_layer_sched.sv
// Layer sequencer: steps through a per-layer shape table, driving load requests and conv starts.
// Define CONV_SCHED_WATCHDOG_EN to add a LOAD/CONV watchdog that raises err_wdt and aborts.
module conv_layer_sched #(
  parameter int unsigned MAX_LAYERS = 7,
  parameter int unsigned WDT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [16:0] cfg_wdata,
  input  logic [2:0]  num_layers,
  input  logic        start,
  input  logic        abort,
  input  logic        load_done,
  input  logic        convFinish,
  input  logic        wfifo_wen,
  output logic [2:0]  cnn_state,
  output logic [5:0]  W,
  output logic [5:0]  H,
  output logic [4:0]  C,
  output logic        load_req,
  output logic        convStart,
  output logic        busy,
  output logic        done,
  output logic        err_cnt,
  output logic        err_cfg,
  output logic        err_wdt
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StConv, StNext, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d, n_q, n_d;
  logic        skip_q, skip_d;
  logic [10:0] beat_q, beat_d, area;
  logic        err_cnt_q, err_cnt_d, err_cfg_q, err_cfg_d;
  logic [5:0]  w_q, w_d, h_q, h_d;
  logic [4:0]  c_q, c_d;
  logic        load_req_q, load_req_d, conv_start_q, conv_start_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [16:0] entry;
  logic        tbl_we;
  logic [16:0] tbl_q [MAX_LAYERS];
`ifdef CONV_SCHED_WATCHDOG_EN
  logic [15:0] wdt_q, wdt_d;
  logic        err_wdt_q, err_wdt_d;
`endif

  // The table is frozen for the whole run; a start in the same cycle takes priority.
  assign tbl_we = (state_q == StIdle) && !start && cfg_we && (32'(cfg_addr) < MAX_LAYERS);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    skip_d    = skip_q;
    beat_d    = beat_q;
    err_cnt_d = err_cnt_q;
    err_cfg_d = err_cfg_q;
`ifdef CONV_SCHED_WATCHDOG_EN
    err_wdt_d = err_wdt_q;
    wdt_d     = wdt_q;
`endif
    area = {5'd0, w_q} * {5'd0, h_q};
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (num_layers != 3'd0 && 32'(num_layers) <= MAX_LAYERS) begin
            n_d       = num_layers;
            idx_d     = 3'd0;
            err_cnt_d = 1'b0;
            err_cfg_d = 1'b0;
`ifdef CONV_SCHED_WATCHDOG_EN
            err_wdt_d = 1'b0;
`endif
            state_d   = StLoad;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (w_q == 6'd0 || h_q == 6'd0 || c_q == 5'd0) begin
          err_cfg_d = 1'b1;
          skip_d    = 1'b1;
          state_d   = StNext;
        end else if (load_done) begin
          skip_d  = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        beat_d  = 11'd0;
        state_d = StConv;
      end
      StConv: begin
        if (wfifo_wen) beat_d = beat_q + 11'd1;
        if (convFinish) state_d = StNext;
      end
      StNext: begin
        if (!skip_q && beat_q != area) err_cnt_d = 1'b1;
        if (idx_q == n_q - 3'd1) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StLoad;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef CONV_SCHED_WATCHDOG_EN
    if (state_q == StLoad || state_q == StConv) begin
      wdt_d = wdt_q + 16'd1;
      if (wdt_d == 16'(WDT_CYCLES)) begin
        err_wdt_d = 1'b1;
        state_d   = StIdle;
      end
    end
`endif
    if (abort) state_d = StIdle;
`ifdef CONV_SCHED_WATCHDOG_EN
    if (state_d != state_q) wdt_d = 16'd0;
`endif

    // Outputs are registered from the next state so they line up with the state they describe.
    entry = tbl_q[idx_d];
    w_d   = w_q;
    h_d   = h_q;
    c_d   = c_q;
    if (state_d == StLoad && state_q != StLoad) {w_d, h_d, c_d} = entry;
    load_req_d   = (state_d == StLoad) && (entry[16:11] != 6'd0) && (entry[10:5] != 6'd0) &&
                   (entry[4:0] != 5'd0);
    conv_start_d = (state_d == StStart);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      n_q          <= 3'd0;
      skip_q       <= 1'b0;
      beat_q       <= 11'd0;
      err_cnt_q    <= 1'b0;
      err_cfg_q    <= 1'b0;
      w_q          <= 6'd0;
      h_q          <= 6'd0;
      c_q          <= 5'd0;
      load_req_q   <= 1'b0;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tbl_q        <= '{default: '0};
`ifdef CONV_SCHED_WATCHDOG_EN
      wdt_q        <= 16'd0;
      err_wdt_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      skip_q       <= skip_d;
      beat_q       <= beat_d;
      err_cnt_q    <= err_cnt_d;
      err_cfg_q    <= err_cfg_d;
      w_q          <= w_d;
      h_q          <= h_d;
      c_q          <= c_d;
      load_req_q   <= load_req_d;
      conv_start_q <= conv_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      if (tbl_we) tbl_q[cfg_addr] <= cfg_wdata;
`ifdef CONV_SCHED_WATCHDOG_EN
      wdt_q        <= wdt_d;
      err_wdt_q    <= err_wdt_d;
`endif
    end
  end

  assign cnn_state = idx_q;
  assign W         = w_q;
  assign H         = h_q;
  assign C         = c_q;
  assign load_req  = load_req_q;
  assign convStart = conv_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cnt   = err_cnt_q;
  assign err_cfg   = err_cfg_q;
`ifdef CONV_SCHED_WATCHDOG_EN
  assign err_wdt   = err_wdt_q;
`else
  assign err_wdt   = 1'b0;
`endif

endmodule
